// File: rtl/memory_sdp.sv
// Simple-dual-port synchronous RAM with per-lane write enables, selectable
// read-during-write behaviour and a clear sequencer that zeroes the array after reset.
module memory_sdp #(
    parameter int unsigned AddrWidth    = 8,
    parameter int unsigned DataWidth    = 16,
    parameter int unsigned LaneWidth    = 8,
    parameter int unsigned RdwMode      = 0,
    parameter int unsigned ClearOnReset = 1
) (
    input  logic                             Clk,
    input  logic                             Reset_N,
    input  logic                             Write_EN,
    input  logic [AddrWidth-1:0]             Wr_Addr,
    input  logic [DataWidth/LaneWidth-1:0]   Wr_Lanes,
    input  logic [DataWidth-1:0]             DIn,
    input  logic                             Read_EN,
    input  logic [AddrWidth-1:0]             Rd_Addr,
    output logic [DataWidth-1:0]             DOut,
    output logic                             DOut_Valid,
    output logic                             Busy
);

    localparam int unsigned Lanes = DataWidth / LaneWidth;
    localparam int unsigned Depth = 2 ** AddrWidth;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t ResetState = (ClearOnReset != 0) ? ST_CLEAR : ST_READY;

    state_t                 state;
    state_t                 state_next;
    logic [AddrWidth-1:0]   clr_cnt;
    logic [AddrWidth-1:0]   clr_cnt_next;

    logic                   wr_en_c;
    logic [AddrWidth-1:0]   wr_addr_c;
    logic [Lanes-1:0]       wr_lanes_c;
    logic [DataWidth-1:0]   wr_data_c;
    logic                   rd_en_c;

    logic [DataWidth-1:0]   rd_old_c;
    logic [DataWidth-1:0]   rd_new_c;
    logic [DataWidth-1:0]   rd_data_c;

    logic [DataWidth-1:0]   mem [Depth];

    // Sequencer state register; reset restarts the clear from address 0.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state   <= ResetState;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Next state: walk every address once, leave CLEAR after the last word.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (state == ST_CLEAR) begin
            clr_cnt_next = clr_cnt + AddrWidth'(1);
            if (clr_cnt == LastAddr) begin
                state_next = ST_READY;
            end
        end
    end

    // Array port control: the sequencer owns the write port while clearing.
    always_comb begin
        wr_en_c    = 1'b0;
        wr_addr_c  = Wr_Addr;
        wr_lanes_c = Wr_Lanes;
        wr_data_c  = DIn;
        rd_en_c    = 1'b0;
        if (state == ST_CLEAR) begin
            wr_en_c    = 1'b1;
            wr_addr_c  = clr_cnt;
            wr_lanes_c = '1;
            wr_data_c  = '0;
        end else begin
            wr_en_c = !Write_EN;
            rd_en_c = !Read_EN;
        end
    end

    assign Busy = (state == ST_CLEAR);

    // Storage with per-lane byte enables; no reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        for (int unsigned i = 0; i < Lanes; i++) begin
            if (wr_en_c && wr_lanes_c[i]) begin
                mem[wr_addr_c][i*LaneWidth +: LaneWidth] <= wr_data_c[i*LaneWidth +: LaneWidth];
            end
        end
    end

    // Same-address bypass builds the merged word for write-first mode.
    always_comb begin
        rd_old_c = mem[Rd_Addr];
        rd_new_c = rd_old_c;
        for (int unsigned i = 0; i < Lanes; i++) begin
            if (wr_en_c && wr_lanes_c[i] && (wr_addr_c == Rd_Addr)) begin
                rd_new_c[i*LaneWidth +: LaneWidth] = wr_data_c[i*LaneWidth +: LaneWidth];
            end
        end
        rd_data_c = (RdwMode == 0) ? rd_new_c : rd_old_c;
    end

    // Registered read port; DOut holds between reads.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            DOut       <= '0;
            DOut_Valid <= 1'b0;
        end else begin
            DOut_Valid <= rd_en_c;
            if (rd_en_c) begin
                DOut <= rd_data_c;
            end
        end
    end

endmodule

// File: tb/tb_memory_sdp.sv
// Bench for memory_sdp: three instances (write-first, read-first, no-clear) share
// stimulus and are checked against a word-level model plus directed vectors.
module tb_memory_sdp;

    logic        Clk;
    logic        Reset_N;
    logic        Write_EN;
    logic [7:0]  Wr_Addr;
    logic [1:0]  Wr_Lanes;
    logic [15:0] DIn;
    logic        Read_EN;
    logic [7:0]  Rd_Addr;

    logic [15:0] dout0, dout1, dout2;
    logic [2:0]  valid_v;
    logic [2:0]  busy_v;

    int checks   = 0;
    int failures = 0;

    memory_sdp #(.AddrWidth(8), .DataWidth(16), .LaneWidth(8), .RdwMode(0), .ClearOnReset(1)) dut0 (
        .Clk(Clk), .Reset_N(Reset_N), .Write_EN(Write_EN), .Wr_Addr(Wr_Addr), .Wr_Lanes(Wr_Lanes),
        .DIn(DIn), .Read_EN(Read_EN), .Rd_Addr(Rd_Addr), .DOut(dout0), .DOut_Valid(valid_v[0]),
        .Busy(busy_v[0]));
    memory_sdp #(.AddrWidth(8), .DataWidth(16), .LaneWidth(8), .RdwMode(1), .ClearOnReset(1)) dut1 (
        .Clk(Clk), .Reset_N(Reset_N), .Write_EN(Write_EN), .Wr_Addr(Wr_Addr), .Wr_Lanes(Wr_Lanes),
        .DIn(DIn), .Read_EN(Read_EN), .Rd_Addr(Rd_Addr), .DOut(dout1), .DOut_Valid(valid_v[1]),
        .Busy(busy_v[1]));
    memory_sdp #(.AddrWidth(8), .DataWidth(16), .LaneWidth(8), .RdwMode(0), .ClearOnReset(0)) dut2 (
        .Clk(Clk), .Reset_N(Reset_N), .Write_EN(Write_EN), .Wr_Addr(Wr_Addr), .Wr_Lanes(Wr_Lanes),
        .DIn(DIn), .Read_EN(Read_EN), .Rd_Addr(Rd_Addr), .DOut(dout2), .DOut_Valid(valid_v[2]),
        .Busy(busy_v[2]));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: per instance word array with a known-bits mask
    int          p_rdw [3] = '{0, 1, 0};
    int          p_clr [3] = '{1, 1, 0};
    logic [15:0] m_mem   [3][256];
    logic [15:0] m_known [3][256];
    logic [15:0] m_dout  [3];
    logic [15:0] m_dmask [3];
    logic        m_valid [3];
    int          m_busy  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_dout[k]  = 16'h0;
            m_dmask[k] = 16'hFFFF;
            m_valid[k] = 1'b0;
            m_busy[k]  = (p_clr[k] != 0) ? 256 : 0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] old_w, old_k;
        if (!Reset_N) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (m_busy[k] > 0) begin
                m_busy[k]--;
                m_valid[k] = 1'b0;
                if (m_busy[k] == 0) begin
                    for (int a = 0; a < 256; a++) begin
                        m_mem[k][a]   = 16'h0;
                        m_known[k][a] = 16'hFFFF;
                    end
                end
                continue;
            end
            old_w = m_mem[k][Rd_Addr];
            old_k = m_known[k][Rd_Addr];
            if (!Write_EN) begin
                for (int i = 0; i < 2; i++) begin
                    if (Wr_Lanes[i]) begin
                        m_mem[k][Wr_Addr][i*8 +: 8]   = DIn[i*8 +: 8];
                        m_known[k][Wr_Addr][i*8 +: 8] = 8'hFF;
                    end
                end
            end
            m_valid[k] = !Read_EN;
            if (!Read_EN) begin
                m_dout[k]  = (p_rdw[k] != 0) ? old_w : m_mem[k][Rd_Addr];
                m_dmask[k] = (p_rdw[k] != 0) ? old_k : m_known[k][Rd_Addr];
            end
        end
    endtask

    function automatic logic [15:0] dout_of(input int k);
        case (k)
            0:       return dout0;
            1:       return dout1;
            default: return dout2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp,
                       input logic [31:0] mask);
        checks++;
        if ($isunknown(got & mask) || (((got ^ exp) & mask) != 32'h0)) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d_dout", k), 32'(dout_of(k)), 32'(m_dout[k]), 32'(m_dmask[k]));
            chk($sformatf("dut%0d_valid", k), 32'(valid_v[k]), 32'(m_valid[k]), 32'h1);
            chk($sformatf("dut%0d_busy", k), 32'(busy_v[k]), 32'(m_busy[k] > 0), 32'h1);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic idle_in();
        Write_EN = 1'b1;
        Read_EN  = 1'b1;
    endtask

    task automatic drive(input logic we_n, input logic [7:0] wa, input logic [1:0] ln,
                         input logic [15:0] d, input logic re_n, input logic [7:0] ra);
        Write_EN = we_n; Wr_Addr = wa; Wr_Lanes = ln; DIn = d; Read_EN = re_n; Rd_Addr = ra;
    endtask

    typedef struct {
        logic        we_n;
        logic [7:0]  wa;
        logic [1:0]  lanes;
        logic [15:0] din;
        logic        re_n;
        logic [7:0]  ra;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic        expv;
    } vec_t;

    function automatic vec_t mk(input logic we_n, input logic [7:0] wa, input logic [1:0] ln,
                                input logic [15:0] d, input logic re_n, input logic [7:0] ra,
                                input logic [15:0] e0, input logic [15:0] e1, input logic ev);
        vec_t v;
        v.we_n = we_n; v.wa = wa; v.lanes = ln; v.din = d; v.re_n = re_n; v.ra = ra;
        v.exp0 = e0; v.exp1 = e1; v.expv = ev;
        return v;
    endfunction

    initial begin
        vec_t vq[$];
        int   n;

        drive(1'b1, 8'h0, 2'b00, 16'h0, 1'b1, 8'h0);
        Reset_N = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int k = 0; k < 3; k++) begin
                m_mem[k][a]   = 16'h0;
                m_known[k][a] = 16'h0;
            end
        end
        #2;
        Reset_N = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 3; i++) cycle();
        Reset_N = 1'b1;
        #1;
        chk("rel_busy_clear", 32'(busy_v[0]), 32'h1, 32'h1);
        chk("rel_busy_noclear", 32'(busy_v[2]), 32'h0, 32'h1);

        // No-clear instance works at once while the others ignore the ports
        drive(1'b0, 8'hFF, 2'b11, 16'hC0DE, 1'b1, 8'h0);
        cycle();
        drive(1'b1, 8'h0, 2'b00, 16'h0, 1'b0, 8'hFF);
        cycle();
        chk("noclear_dout", 32'(dout2), 32'hC0DE, 32'hFFFF);
        chk("noclear_valid", 32'(valid_v[2]), 32'h1, 32'h1);
        chk("busy_ignores_read", 32'(valid_v[0]), 32'h0, 32'h1);
        idle_in();
        n = 2;
        while (busy_v[0] && n < 1000) begin
            cycle();
            n++;
        end
        chk("clear_len", 32'(n), 32'd256, 32'hFFFFFFFF);

        // Data written before a second reset must be wiped by the clear
        drive(1'b0, 8'h10, 2'b11, 16'hBEEF, 1'b1, 8'h0);
        cycle();
        drive(1'b1, 8'h0, 2'b00, 16'h0, 1'b0, 8'h10);
        cycle();
        chk("preload_dout", 32'(dout0), 32'hBEEF, 32'hFFFF);
        idle_in();
        #3;
        Reset_N = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        Reset_N = 1'b1;
        for (int i = 0; i < 100; i++) cycle();
        Reset_N = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        cycle();
        Reset_N = 1'b1;
        n = 0;
        while (busy_v[0] && n < 1000) begin
            if (n == 10) drive(1'b0, 8'h20, 2'b11, 16'h5555, 1'b1, 8'h0);
            else idle_in();
            cycle();
            n++;
        end
        chk("restart_clear_len", 32'(n), 32'd256, 32'hFFFFFFFF);
        drive(1'b1, 8'h0, 2'b00, 16'h0, 1'b0, 8'h10);
        cycle();
        chk("cleared_0x10", 32'(dout0), 32'h0, 32'hFFFF);
        drive(1'b1, 8'h0, 2'b00, 16'h0, 1'b0, 8'h20);
        cycle();
        chk("ignored_wr_0x20", 32'(dout1), 32'h0, 32'hFFFF);
        chk("noclear_wr_0x20", 32'(dout2), 32'h5555, 32'hFFFF);

        // Directed vectors: lanes, read-during-write, streaming, hold
        vq.push_back(mk(1'b0, 8'h05, 2'b11, 16'h1234, 1'b1, 8'h00, 16'h0000, 16'h0000, 1'b0));
        vq.push_back(mk(1'b0, 8'h05, 2'b10, 16'hAB00, 1'b1, 8'h00, 16'h0000, 16'h0000, 1'b0));
        vq.push_back(mk(1'b1, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h05, 16'hAB34, 16'hAB34, 1'b1));
        vq.push_back(mk(1'b0, 8'h05, 2'b00, 16'hFFFF, 1'b0, 8'h05, 16'hAB34, 16'hAB34, 1'b1));
        vq.push_back(mk(1'b1, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h05, 16'hAB34, 16'hAB34, 1'b1));
        vq.push_back(mk(1'b0, 8'h07, 2'b11, 16'h1111, 1'b1, 8'h00, 16'hAB34, 16'hAB34, 1'b0));
        vq.push_back(mk(1'b0, 8'h07, 2'b11, 16'h2222, 1'b0, 8'h07, 16'h2222, 16'h1111, 1'b1));
        vq.push_back(mk(1'b1, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h07, 16'h2222, 16'h2222, 1'b1));
        vq.push_back(mk(1'b0, 8'h05, 2'b01, 16'h00CD, 1'b0, 8'h05, 16'hABCD, 16'hAB34, 1'b1));
        vq.push_back(mk(1'b1, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h05, 16'hABCD, 16'hABCD, 1'b1));
        vq.push_back(mk(1'b0, 8'h08, 2'b11, 16'h0BAD, 1'b0, 8'h05, 16'hABCD, 16'hABCD, 1'b1));
        vq.push_back(mk(1'b1, 8'h00, 2'b00, 16'h0000, 1'b0, 8'h08, 16'h0BAD, 16'h0BAD, 1'b1));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1'b0, 8'(i), 2'b11, 16'(16'hA0 + i), 1'b1, 8'h00, 16'h0BAD, 16'h0BAD, 1'b0));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1'b1, 8'h00, 2'b00, 16'h0, 1'b0, 8'(i), 16'(16'hA0 + i), 16'(16'hA0 + i), 1'b1));
        vq.push_back(mk(1'b1, 8'h00, 2'b00, 16'h0000, 1'b1, 8'h00, 16'h00A3, 16'h00A3, 1'b0));
        vq.push_back(mk(1'b1, 8'h00, 2'b00, 16'h0000, 1'b1, 8'h00, 16'h00A3, 16'h00A3, 1'b0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].we_n, vq[i].wa, vq[i].lanes, vq[i].din, vq[i].re_n, vq[i].ra);
            cycle();
            chk($sformatf("vec%0d_dout_wf", i), 32'(dout0), 32'(vq[i].exp0), 32'hFFFF);
            chk($sformatf("vec%0d_dout_rf", i), 32'(dout1), 32'(vq[i].exp1), 32'hFFFF);
            chk($sformatf("vec%0d_valid", i), 32'(valid_v[0]), 32'(vq[i].expv), 32'h1);
        end

        // Random traffic on a narrow address window to force collisions
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
            cycle();
        end
        idle_in();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
